// File: rtl/team_06_sram_delay_line_if.sv
`default_nettype none
// ============================================================================
//  Module      : team_06_sram_delay_line_if
//  Description : Request/response bundle between the delay line and the
//                wishbone manager's user-side port (CPU_DAT_I/ADR_I/SEL_I/
//                WRITE_I/READ_I out, CPU_DAT_O/BUSY_O back).
//  Revision    : 1.0 - initial release
// ============================================================================
interface team_06_sram_delay_line_if;
    logic [31:0] bus_wdata;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic        bus_write;
    logic        bus_read;
    logic [31:0] bus_rdata;
    logic        bus_busy;

    // Delay line side: issues requests, consumes read data and busy.
    modport master (
        output bus_wdata, bus_addr, bus_sel, bus_write, bus_read,
        input  bus_rdata, bus_busy
    );

    // Manager side: accepts requests, returns read data and busy.
    modport slave (
        input  bus_wdata, bus_addr, bus_sel, bus_write, bus_read,
        output bus_rdata, bus_busy
    );
endinterface
`default_nettype wire

// File: rtl/team_06_sram_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : team_06_sram_delay_line
//  Description : SRAM-backed circular delay line. Packs SAMPLE_W-bit samples
//                into 32-bit words through the wishbone manager and returns
//                the sample written `delay` samples earlier (clamped to
//                DEPTH-1). Bypass mode passes samples straight through.
//                Optional macro TEAM_06_DELAY_MIX_EN: output becomes
//                (sample + delayed) >>> 1 instead of the delayed sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module team_06_sram_delay_line #(
    parameter int          SAMPLE_W    = 8,
    parameter int          DEPTH_WORDS = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h3300_0000
) (
    input  wire logic                hwclk,
    input  wire logic                reset,
    input  wire logic                enable,
    input  wire logic [SAMPLE_W-1:0] sample_in,
    input  wire logic                sample_valid,
    input  wire logic [15:0]         delay,
    output logic      [SAMPLE_W-1:0] sample_out,
    output logic                     out_valid,
    output logic                     overrun,
    team_06_sram_delay_line_if.master bus
);

    localparam int c_LANES = 32 / SAMPLE_W;
    localparam int c_BYTES = SAMPLE_W / 8;
    localparam int c_DEPTH = DEPTH_WORDS * c_LANES;
    localparam int c_IDX_W = $clog2(c_DEPTH);
    localparam logic [3:0]         c_SEL_BASE = 4'((1 << c_BYTES) - 1);
    localparam logic [c_IDX_W-1:0] c_MAX_IDX  = c_IDX_W'(c_DEPTH - 1);
    localparam logic [c_IDX_W:0]   c_FULL     = (c_IDX_W + 1)'(c_DEPTH);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_WR_REQ = 3'd1;
    localparam logic [2:0] c_WR_HI  = 3'd2;
    localparam logic [2:0] c_WR_LO  = 3'd3;
    localparam logic [2:0] c_RD_REQ = 3'd4;
    localparam logic [2:0] c_RD_HI  = 3'd5;
    localparam logic [2:0] c_RD_LO  = 3'd6;
    localparam logic [2:0] c_OUT    = 3'd7;

    // Byte address of the SRAM word holding sample index idx.
    function automatic logic [31:0] f_word_addr(input logic [c_IDX_W-1:0] idx);
        return BASE_ADDR + ((32'(idx) / c_LANES) * 32'd4);
    endfunction

    // Lane of sample index idx within its word (always 0 for 32-bit samples).
    function automatic logic [1:0] f_lane(input logic [c_IDX_W-1:0] idx);
        return 2'(32'(idx) % c_LANES);
    endfunction

    // Byte-enable mask covering one lane; lane 0 sits in the low bytes.
    function automatic logic [3:0] f_sel(input logic [1:0] lane);
        return 4'(c_SEL_BASE << (32'(lane) * c_BYTES));
    endfunction

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [c_IDX_W-1:0]  r_wr_idx;
    logic [c_IDX_W-1:0]  r_rd_idx;
    logic [c_IDX_W-1:0]  r_d;
    logic [c_IDX_W:0]    r_fill;

    logic [31:0]         r_bus_wdata, w_bus_wdata;
    logic [31:0]         r_bus_addr,  w_bus_addr;
    logic [3:0]          r_bus_sel,   w_bus_sel;
    logic                r_bus_write, w_bus_write;
    logic                r_bus_read,  w_bus_read;
    logic [SAMPLE_W-1:0] r_sample_out, w_sample_out;
    logic                r_out_valid, w_out_valid;
    logic                r_overrun,   w_overrun;

    logic                w_idle;
    logic                w_accept;
    logic                w_bypass;
    logic                w_wr_done;
    logic                w_rd_done;
    logic [31:0]         w_delay_ext;
    logic [c_IDX_W-1:0]  w_d;
    logic [SAMPLE_W-1:0] w_lane_data;
    logic [SAMPLE_W-1:0] w_delayed;
    logic [SAMPLE_W-1:0] w_result;

    assign w_idle      = (r_state == c_IDLE);
    assign w_accept    = w_idle && sample_valid && enable;
    assign w_bypass    = w_idle && sample_valid && !enable;
    assign w_wr_done   = (r_state == c_WR_LO) && !bus.bus_busy;
    assign w_rd_done   = (r_state == c_RD_LO) && !bus.bus_busy;
    assign w_delay_ext = {16'd0, delay};
    assign w_d         = (w_delay_ext > 32'(c_DEPTH - 1)) ? c_MAX_IDX : c_IDX_W'(w_delay_ext);

    // Lane pick from the returned word; a delay reaching past the samples
    // written so far reads as silence even though the bus read still happens.
    assign w_lane_data = SAMPLE_W'(bus.bus_rdata >> (32'(f_lane(r_rd_idx)) * SAMPLE_W));
    assign w_delayed   = ({1'b0, r_d} >= r_fill) ? '0 : w_lane_data;

`ifdef TEAM_06_DELAY_MIX_EN
    logic [SAMPLE_W-1:0] r_sample;
    logic [SAMPLE_W:0]   w_sum;

    // Sign-extend both terms by one bit; dropping the LSB of the sum is an
    // arithmetic shift right with floor rounding.
    assign w_sum    = {r_sample[SAMPLE_W-1], r_sample} + {w_delayed[SAMPLE_W-1], w_delayed};
    assign w_result = w_sum[SAMPLE_W:1];

    // Keep the dry sample for the mix stage.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_sample <= '0;
        end else if (w_accept) begin
            r_sample <= sample_in;
        end
    end
`else
    assign w_result = w_delayed;
`endif

    // State register.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: write handshake, then read handshake, then one output cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (w_accept)      w_next_state = c_WR_REQ;
            c_WR_REQ:                    w_next_state = c_WR_HI;
            c_WR_HI:  if (bus.bus_busy)  w_next_state = c_WR_LO;
            c_WR_LO:  if (!bus.bus_busy) w_next_state = c_RD_REQ;
            c_RD_REQ:                    w_next_state = c_RD_HI;
            c_RD_HI:  if (bus.bus_busy)  w_next_state = c_RD_LO;
            c_RD_LO:  if (!bus.bus_busy) w_next_state = c_OUT;
            c_OUT:                       w_next_state = c_IDLE;
            default:                     w_next_state = c_IDLE;
        endcase
    end

    // Next values of the registered outputs; requests are raised on the edge
    // that enters WR_REQ/RD_REQ so they are high for exactly that state.
    always_comb begin
        w_bus_write  = 1'b0;
        w_bus_read   = 1'b0;
        w_bus_addr   = r_bus_addr;
        w_bus_sel    = r_bus_sel;
        w_bus_wdata  = r_bus_wdata;
        w_out_valid  = 1'b0;
        w_sample_out = r_sample_out;
        w_overrun    = sample_valid && !w_idle;
        if (w_accept) begin
            w_bus_write = 1'b1;
            w_bus_addr  = f_word_addr(r_wr_idx);
            w_bus_sel   = f_sel(f_lane(r_wr_idx));
            w_bus_wdata = {c_LANES{sample_in}};
        end
        if (w_bypass) begin
            w_out_valid  = 1'b1;
            w_sample_out = sample_in;
        end
        if (w_wr_done) begin
            w_bus_read = 1'b1;
            w_bus_addr = f_word_addr(r_rd_idx);
            w_bus_sel  = f_sel(f_lane(r_rd_idx));
        end
        if (w_rd_done) begin
            w_out_valid  = 1'b1;
            w_sample_out = w_result;
        end
    end

    // Output registers.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_bus_write  <= 1'b0;
            r_bus_read   <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_sel    <= '0;
            r_bus_wdata  <= '0;
            r_out_valid  <= 1'b0;
            r_sample_out <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_bus_write  <= w_bus_write;
            r_bus_read   <= w_bus_read;
            r_bus_addr   <= w_bus_addr;
            r_bus_sel    <= w_bus_sel;
            r_bus_wdata  <= w_bus_wdata;
            r_out_valid  <= w_out_valid;
            r_sample_out <= w_sample_out;
            r_overrun    <= w_overrun;
        end
    end

    // Buffer pointers: read index fixed at accept, write index and fill
    // advance once the write has completed. DEPTH is a power of two, so the
    // index wraps naturally.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_d      <= '0;
            r_fill   <= '0;
        end else begin
            if (w_accept) begin
                r_d      <= w_d;
                r_rd_idx <= r_wr_idx - w_d;
            end
            if (w_wr_done) begin
                r_wr_idx <= r_wr_idx + 1'b1;
                if (r_fill != c_FULL) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    assign bus.bus_write = r_bus_write;
    assign bus.bus_read  = r_bus_read;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_sel   = r_bus_sel;
    assign bus.bus_wdata = r_bus_wdata;
    assign sample_out    = r_sample_out;
    assign out_valid     = r_out_valid;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire
